// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage in front of a combinational instruction memory. Holds the PC,
//   drives it straight out as the word address, and captures the returned
//   word into an output register with a valid/ready handshake toward decode.
//   Supports start, backpressure stall, redirect with flush, and halt on a
//   sentinel instruction word.
//
//   Optional build macro: FETCH_PERF_CNT_EN
//     When defined, adds fetch_count, a saturating 16-bit count of completed
//     output handshakes. It is cleared only by rst_n.
//
//   Ports
//     clk           in   clock, all state on rising edge
//     rst_n         in   asynchronous active-low reset
//     start         in   leave IDLE and begin fetching
//     im_addr       out  word address to instruction memory (= pc)
//     im_data       in   read data for im_addr, same cycle
//     redir_valid   in   redirect request
//     redir_target  in   new pc on redirect
//     out_valid     out  out_instr/out_pc hold a fetched instruction
//     out_ready     in   downstream accepts this cycle
//     out_instr     out  fetched instruction
//     out_pc        out  address of out_instr
//     halted        out  high while in HALT
//     fetch_count   out  handshake count (FETCH_PERF_CNT_EN only)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | after reset, pc parked at RESET_PC, waiting for start
//   RUN   | fetching one word per cycle when the output register can take it
//   HALT  | halt word fetched, pc parked on it, waiting for a redirect

module instruction_fetch #(
    parameter int                 ADDR_W    = 6,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_data,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]   out_pc_q, out_pc_d;

    logic                redirect;
    logic                fire;
    logic                is_halt_word;

    // Redirects are only honoured once fetching has been started.
    assign redirect     = redir_valid && (state_q != S_IDLE);
    assign fire         = (state_q == S_RUN) && !redir_valid && (!out_valid_q || out_ready);
    assign is_halt_word = (im_data == HALT_WORD);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (redir_valid)                 state_d = S_RUN;
                else if (fire && is_halt_word)   state_d = S_HALT;
            end
            S_HALT: begin
                if (redir_valid) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        halted = (state_q == S_HALT);
    end

    // Datapath: pc and output register
    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (redirect) begin
            // Flush wins over a same-cycle handshake: the pending word is dropped.
            pc_d        = redir_target;
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_instr_d = im_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            // The halt word is presented but the pc stays parked on it.
            if (!is_halt_word) pc_d = pc_q + ADDR_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign im_addr   = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (out_valid_q && out_ready && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  im_addr;
    logic [31:0] im_data;
    logic        redir_valid;
    logic [5:0]  redir_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [5:0]  out_pc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
`endif

    logic [31:0] mem [0:63];
    logic [5:0]  exp_q [$];
    logic [5:0]  exp_pc;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    assign im_data = mem[im_addr];

    instruction_fetch #(
        .ADDR_W(6), .DATA_W(32), .RESET_PC(6'd0), .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .im_addr(im_addr),
        .im_data(im_data),
        .redir_valid(redir_valid),
        .redir_target(redir_target),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    // Consume a presented word when the handshake completes, then advance one clock.
    task automatic cycle();
        if (out_valid && out_ready && !redir_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got out_pc=%0d, expected no word", out_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                if (out_pc !== exp_pc || out_instr !== mem[exp_pc]) begin
                    bad++;
                    $display("FAIL sb_word: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             out_pc, out_instr, exp_pc, mem[exp_pc]);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_empty(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d words not delivered, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; redir_valid = 1'b0; redir_target = '0; out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || im_addr !== 6'd0 || halted !== 1'b0 ||
            out_pc !== 6'd0 || out_instr !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: valid=%b addr=%0d halted=%b pc=%0d instr=%h, expected 0s",
                     out_valid, im_addr, halted, out_pc, out_instr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_halt();
        out_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(6'(i));
        cycle();
        start = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_latency: out_valid=%b one cycle after start, expected 0", out_valid);
        end
        for (int i = 0; i < 5; i++) cycle();
        check_empty("halt_stream");
        total++;
        if (halted !== 1'b1 || im_addr !== 6'd3) begin
            bad++;
            $display("FAIL halt_state: halted=%b im_addr=%0d, expected 1 and 3", halted, im_addr);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (out_valid !== 1'b0 || im_addr !== 6'd3 || halted !== 1'b1) begin
                bad++;
                $display("FAIL halt_hold: valid=%b addr=%0d halted=%b, expected 0 3 1",
                         out_valid, im_addr, halted);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if (fetch_count !== 16'd4) begin
            bad++;
            $display("FAIL perf_count: got %0d, expected 4", fetch_count);
        end
`endif
        // start is ignored while halted
        start = 1'b1;
        cycle();
        start = 1'b0;
        total++;
        if (halted !== 1'b1 || im_addr !== 6'd3) begin
            bad++;
            $display("FAIL start_in_halt: halted=%b addr=%0d, expected 1 3", halted, im_addr);
        end
    endtask

    task automatic test_redirect_from_halt();
        redir_valid = 1'b1; redir_target = 6'd10;
        cycle();
        redir_valid = 1'b0;
        total++;
        if (halted !== 1'b0 || im_addr !== 6'd10 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL halt_redirect: halted=%b addr=%0d valid=%b, expected 0 10 0",
                     halted, im_addr, out_valid);
        end
        exp_q.push_back(6'd10);
        exp_q.push_back(6'd11);
        cycle();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 6'd10) begin
            bad++;
            $display("FAIL resume_pc: valid=%b pc=%0d, expected 1 10", out_valid, out_pc);
        end
        cycle();
        cycle();
        out_ready = 1'b0;
        check_empty("resume_stream");
        // start pulse while running must not disturb the pc
        start = 1'b1;
        cycle();
        start = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 6'd12 || im_addr !== 6'd13) begin
            bad++;
            $display("FAIL start_in_run: valid=%b pc=%0d addr=%0d, expected 1 12 13",
                     out_valid, out_pc, im_addr);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b1; redir_valid = 1'b1; redir_target = 6'd4;
        cycle();
        redir_valid = 1'b0;
        for (int i = 4; i < 8; i++) exp_q.push_back(6'(i));
        cycle();
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (out_valid !== 1'b1 || out_pc !== 6'd5 || out_instr !== mem[5] || im_addr !== 6'd6) begin
                bad++;
                $display("FAIL stall_hold: valid=%b pc=%0d instr=%h addr=%0d, expected 1 5 %h 6",
                         out_valid, out_pc, out_instr, im_addr, mem[5]);
            end
        end
        out_ready = 1'b1;
        cycle();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 6'd6) begin
            bad++;
            $display("FAIL stall_release: valid=%b pc=%0d, expected 1 6", out_valid, out_pc);
        end
        cycle();
        cycle();
        check_empty("stall_stream");
    endtask

    task automatic test_redirect_flush();
        // out_valid=1 (pc 8) and out_ready=1 while redirecting: word is dropped
        out_ready = 1'b1; redir_valid = 1'b1; redir_target = 6'd40;
        cycle();
        redir_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || im_addr !== 6'd40) begin
            bad++;
            $display("FAIL flush: valid=%b addr=%0d, expected 0 40", out_valid, im_addr);
        end
        exp_q.push_back(6'd40);
        cycle();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 6'd40 || out_instr !== mem[40]) begin
            bad++;
            $display("FAIL redirect_target: valid=%b pc=%0d instr=%h, expected 1 40 %h",
                     out_valid, out_pc, out_instr, mem[40]);
        end
        cycle();
        out_ready = 1'b0;
        check_empty("redirect_stream");
    endtask

    task automatic test_wrap();
        redir_valid = 1'b1; redir_target = 6'd62;
        cycle();
        redir_valid = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(6'd62);
        exp_q.push_back(6'd63);
        exp_q.push_back(6'd0);
        exp_q.push_back(6'd1);
        cycle();
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 6'd0 || out_instr !== mem[0]) begin
            bad++;
            $display("FAIL wrap: valid=%b pc=%0d instr=%h, expected 1 0 %h",
                     out_valid, out_pc, out_instr, mem[0]);
        end
        cycle();
        cycle();
        out_ready = 1'b0;
        check_empty("wrap_stream");
    endtask

    task automatic test_async_reset();
        // out_valid=1 with pc 2 pending; reset lands between clock edges
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || im_addr !== 6'd0 || halted !== 1'b0 ||
            out_pc !== 6'd0 || out_instr !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: valid=%b addr=%0d halted=%b pc=%0d instr=%h, expected 0s",
                     out_valid, im_addr, halted, out_pc, out_instr);
        end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if (fetch_count !== 16'd0) begin
            bad++;
            $display("FAIL perf_reset: got %0d, expected 0", fetch_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        // redirect in IDLE is ignored
        out_ready = 1'b1; redir_valid = 1'b1; redir_target = 6'd20;
        cycle();
        redir_valid = 1'b0;
        cycle();
        total++;
        if (im_addr !== 6'd0 || out_valid !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL idle_redirect: addr=%0d valid=%b halted=%b, expected 0 0 0",
                     im_addr, out_valid, halted);
        end
        // start and redirect together in IDLE: start wins, pc stays at 0
        start = 1'b1; redir_valid = 1'b1; redir_target = 6'd20;
        cycle();
        start = 1'b0; redir_valid = 1'b0;
        total++;
        if (im_addr !== 6'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_vs_redirect: addr=%0d valid=%b, expected 0 0", im_addr, out_valid);
        end
        exp_q.push_back(6'd0);
        cycle();
        cycle();
        out_ready = 1'b0;
        check_empty("post_reset_stream");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0] = 32'h0000_0011;
        mem[1] = 32'h0000_0022;
        mem[2] = 32'h0000_0033;
        mem[3] = 32'hFFFF_FFFF;

        test_reset();
        test_halt();
        test_redirect_from_halt();
        test_stall();
        test_redirect_flush();
        test_wrap();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
